// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, state encoding and lane-mask helper for the load/store unit.
package lsu_pkg;

  // RV32I load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Lane widths in bits
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [31:0] HALF_MASK = 32'h0000_ffff;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_e;

  // Byte-lane mask for a store of width f3 at byte offset off
  function automatic logic [31:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    lane_mask = BYTE_MASK << {off, 3'b000};
      F3_H:    lane_mask = HALF_MASK << {off[1], 4'b0000};
      default: lane_mask = '1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed lane of a memory word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = word >> {off, 3'b000};

  // Extend the selected lane according to the width code
  always_comb begin
    case (funct3)
      F3_B:    result = {{(WORD_W - BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
      F3_H:    result = {{(WORD_W - HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
      F3_BU:   result = {{(WORD_W - BYTE_W){1'b0}}, shifted[BYTE_W-1:0]};
      F3_HU:   result = {{(WORD_W - HALF_W){1'b0}}, shifted[HALF_W-1:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit in front of a word-only data memory. Sub-word stores become a
// two-cycle read-modify-write during which req_ready is low.
// Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned, out-of-range and illegal
// accesses are suppressed and reported on err; when undefined, addresses are forced to
// alignment, indices wrap modulo MEM_WORDS, illegal width codes act as W and err is 0.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_e  state_q, state_d;
  logic        accept;
  logic        f3_legal;
  logic [2:0]  f3_eff;
  logic [1:0]  off_eff;
  logic [31:0] idx_eff;
  logic        bad;
  logic        is_sw;
  logic        is_sub_store;
  logic [31:0] word_idx;
  logic [31:0] load_result;
  logic [31:0] mem_a_q, mem_wd_q;
  logic [31:0] old_q, mask_q, data_q, idx_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;

  assign word_idx = {2'b00, req_addr[31:2]};
  assign accept   = req_valid && (state_q == ST_IDLE);

  // Width codes a load or store may legally use
  always_comb begin
    if (req_we) begin
      f3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    end else begin
      f3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                 (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic out_of_range;
  logic err_q;

  // Decode with raw request fields and flag anything the memory cannot serve
  always_comb begin
    f3_eff  = req_funct3;
    off_eff = req_addr[1:0];
    idx_eff = word_idx;
    case (req_funct3)
      F3_H, F3_HU: misaligned = req_addr[0];
      F3_W:        misaligned = |req_addr[1:0];
      default:     misaligned = 1'b0;
    endcase
    out_of_range = word_idx >= MEM_WORDS;
    bad          = !f3_legal || misaligned || out_of_range;
  end

  // err pulses the cycle after a bad access is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && bad;
    end
  end

  assign err = err_q;
`else
  // Force alignment, wrap the index and map illegal width codes onto W
  always_comb begin
    f3_eff = f3_legal ? req_funct3 : F3_W;
    case (f3_eff)
      F3_B, F3_BU: off_eff = req_addr[1:0];
      F3_H, F3_HU: off_eff = {req_addr[1], 1'b0};
      default:     off_eff = 2'b00;
    endcase
    idx_eff = word_idx % MEM_WORDS;
    bad     = 1'b0;
  end

  assign err = 1'b0;
`endif

  assign is_sw        = req_we && (f3_eff == F3_W) && !bad;
  assign is_sub_store = req_we && ((f3_eff == F3_B) || (f3_eff == F3_H)) && !bad;

  lsu_load_align u_load_align (
    .word   (mem_rd),
    .off    (off_eff),
    .funct3 (f3_eff),
    .result (load_result)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a sub-word store spends one extra cycle writing the merged word
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept && is_sub_store) state_d = ST_RMW_WR;
      ST_RMW_WR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: memory port holds its last address/data when not actively driven
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    mem_we    = 1'b0;
    mem_a     = mem_a_q;
    mem_wd    = mem_wd_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mem_a = idx_eff;
          if (is_sw) begin
            mem_we = 1'b1;
            mem_wd = req_wdata;
          end
        end
      end
      ST_RMW_WR: begin
        mem_we = 1'b1;
        mem_a  = idx_q;
        mem_wd = (old_q & ~mask_q) | (data_q & mask_q);
      end
      default: ;
    endcase
    // Reset must cut a pending write immediately
    if (!rst_n) mem_we = 1'b0;
  end

  // Memory-port hold registers and load response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a_q     <= '0;
      mem_wd_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      mem_a_q     <= mem_a;
      mem_wd_q    <= mem_wd;
      rsp_valid_q <= accept && !req_we;
      if (accept && !req_we) rsp_rdata_q <= bad ? '0 : load_result;
    end
  end

  // Read phase of a sub-word store: capture old word, lane mask, shifted data and index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      old_q  <= '0;
      mask_q <= '0;
      data_q <= '0;
      idx_q  <= '0;
    end else if (accept && is_sub_store) begin
      old_q  <= mem_rd;
      mask_q <= lane_mask(f3_eff, off_eff);
      data_q <= req_wdata << {off_eff, 3'b000};
      idx_q  <= idx_eff;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
